// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: fetch-state encoding, PC increment and the
// next-PC source encoding used by the sequencer and its select logic.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    FAULT  = 2'd3
  } fetch_state_e;

  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_JREG   = 2'd3
  } npc_sel_e;

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_select.sv
// Combinational next-PC source select, target formation and legality check
// (word alignment plus instruction-ROM range) for the fetch sequencer.
module next_pc_select
  import mips_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int MEM_DEPTH     = 100
) (
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic                     branch,
  input  logic                     zero,
  input  logic [ADDRESS_WIDTH-1:0] branch_offset,
  input  logic                     jump,
  input  logic [25:0]              jump_index,
  input  logic                     jump_reg,
  input  logic [ADDRESS_WIDTH-1:0] reg_target,
  output logic [ADDRESS_WIDTH-1:0] target,
  output logic                     illegal
);

  localparam logic [ADDRESS_WIDTH-1:0] STEP  = ADDRESS_WIDTH'(PC_STEP);
  localparam logic [ADDRESS_WIDTH-1:0] DEPTH = ADDRESS_WIDTH'(MEM_DEPTH);

  logic [ADDRESS_WIDTH-1:0] pc_plus4_s;
  logic [ADDRESS_WIDTH-1:0] branch_tgt_s;
  logic [ADDRESS_WIDTH-1:0] jump_tgt_s;
  logic [ADDRESS_WIDTH-1:0] word_idx_s;
  npc_sel_e                 sel_s;

  assign pc_plus4_s   = pc + STEP;
  assign branch_tgt_s = pc_plus4_s + (branch_offset << 2);
  // Pseudo-direct jump keeps the top nibble of the sequential address.
  assign jump_tgt_s   = {pc_plus4_s[ADDRESS_WIDTH-1:28], jump_index, 2'b00};

  // Priority select: JR, then J/JAL, then taken branch, then sequential.
  always_comb begin
    sel_s = NPC_SEQ;
    if (jump_reg) begin
      sel_s = NPC_JREG;
    end else if (jump) begin
      sel_s = NPC_JUMP;
    end else if (branch && zero) begin
      sel_s = NPC_BRANCH;
    end else begin
      sel_s = NPC_SEQ;
    end
  end

  // Target mux and legality flag.
  always_comb begin
    target = pc_plus4_s;
    case (sel_s)
      NPC_SEQ:    target = pc_plus4_s;
      NPC_BRANCH: target = branch_tgt_s;
      NPC_JUMP:   target = jump_tgt_s;
      NPC_JREG:   target = reg_target;
      default:    target = pc_plus4_s;
    endcase
    word_idx_s = {2'b00, target[ADDRESS_WIDTH-1:2]};
    illegal    = !word_aligned(target[1:0]) || (word_idx_s >= DEPTH);
  end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter with BOOT/RUN/HALTED/FAULT sequencing.
// Optional retired-instruction counter built only when PC_PERF_CNT_EN is defined.
module program_counter_unit
  import mips_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int                     MEM_DEPTH     = 100
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Stall,
  input  logic                     Halt,
  input  logic                     Branch,
  input  logic                     Zero,
  input  logic [ADDRESS_WIDTH-1:0] BranchOffset,
  input  logic                     Jump,
  input  logic [25:0]              JumpIndex,
  input  logic                     JumpReg,
  input  logic [ADDRESS_WIDTH-1:0] RegTarget,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [ADDRESS_WIDTH-1:0] PCPlus4,
  output logic                     Valid,
  output logic                     Halted,
  output logic                     Fault,
  output logic [ADDRESS_WIDTH-1:0] FaultAddr,
  output logic [31:0]              InstrCount
);

  localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(PC_STEP);

  fetch_state_e             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_q, pc_plus4_d;
  logic [ADDRESS_WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic                     valid_q, valid_d;
  logic                     halted_q, halted_d;
  logic                     fault_q, fault_d;
  logic [ADDRESS_WIDTH-1:0] target_s;
  logic                     illegal_s;

  next_pc_select #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .MEM_DEPTH     (MEM_DEPTH)
  ) u_next_pc_select (
    .pc            (pc_q),
    .branch        (Branch),
    .zero          (Zero),
    .branch_offset (BranchOffset),
    .jump          (Jump),
    .jump_index    (JumpIndex),
    .jump_reg      (JumpReg),
    .reg_target    (RegTarget),
    .target        (target_s),
    .illegal       (illegal_s)
  );

  // Next state, next PC and fault capture; Stall outranks Halt, Halt outranks faults.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_VECTOR;
      end
      RUN: begin
        if (Stall) begin
          state_d = RUN;
        end else if (Halt) begin
          state_d = HALTED;
        end else if (illegal_s) begin
          state_d      = FAULT;
          fault_addr_d = target_s;
        end else begin
          pc_d = target_s;
        end
      end
      HALTED:  state_d = HALTED;
      FAULT:   state_d = FAULT;
      default: begin
        state_d = BOOT;
        pc_d    = RESET_VECTOR;
      end
    endcase
    pc_plus4_d = pc_d + STEP;
    valid_d    = (state_d == RUN);
    halted_d   = (state_d == HALTED);
    fault_d    = (state_d == FAULT);
  end

  // Architectural PC, state and status flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      pc_plus4_q   <= RESET_VECTOR + STEP;
      fault_addr_q <= {ADDRESS_WIDTH{1'b0}};
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pc_plus4_q   <= pc_plus4_d;
      fault_addr_q <= fault_addr_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  assign PC        = pc_q;
  assign PCPlus4   = pc_plus4_q;
  assign Valid     = valid_q;
  assign Halted    = halted_q;
  assign Fault     = fault_q;
  assign FaultAddr = fault_addr_q;

`ifdef PC_PERF_CNT_EN
  logic [31:0] instr_count_q, instr_count_d;
  logic        retire_s;

  // An instruction retires on any unstalled RUN edge that does not trap, halt included.
  always_comb begin
    retire_s = (state_q == RUN) && !Stall && (Halt || !illegal_s);
    if (retire_s) begin
      instr_count_d = instr_count_q + 32'd1;
    end else begin
      instr_count_d = instr_count_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      instr_count_q <= 32'd0;
    end else begin
      instr_count_q <= instr_count_d;
    end
  end

  assign InstrCount = instr_count_q;
`else
  assign InstrCount = 32'd0;
`endif

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit: directed scenarios plus a
// randomized run checked against a behavioural fetch model.
module tb_program_counter_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Stall, Halt, Branch, Zero, Jump, JumpReg;
  logic [31:0] BranchOffset, RegTarget;
  logic [25:0] JumpIndex;
  logic [31:0] PC, PCPlus4, FaultAddr, InstrCount;
  logic        Valid, Halted, Fault;

  int checks = 0;
  int errors = 0;

  // Behavioural model: lifecycle flags rather than a state code.
  logic        m_boot, m_run, m_halted, m_fault;
  logic [31:0] m_pc, m_fault_addr, m_count;

  program_counter_unit #(
    .ADDRESS_WIDTH (32),
    .RESET_VECTOR  (32'h0000_0000),
    .MEM_DEPTH     (100)
  ) dut (
    .CLK (CLK), .RST (RST), .Stall (Stall), .Halt (Halt), .Branch (Branch),
    .Zero (Zero), .BranchOffset (BranchOffset), .Jump (Jump), .JumpIndex (JumpIndex),
    .JumpReg (JumpReg), .RegTarget (RegTarget), .PC (PC), .PCPlus4 (PCPlus4),
    .Valid (Valid), .Halted (Halted), .Fault (Fault), .FaultAddr (FaultAddr),
    .InstrCount (InstrCount)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] exp_count();
`ifdef PC_PERF_CNT_EN
    return m_count;
`else
    return 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_run = 1'b0; m_halted = 1'b0; m_fault = 1'b0;
    m_pc = 32'd0; m_fault_addr = 32'd0; m_count = 32'd0;
  endtask

  task automatic model_step();
    logic [31:0] pc4, tgt;
    if (RST) begin
      if (m_boot) begin
        m_boot = 1'b0;
        m_run  = 1'b1;
      end else if (m_run && !Stall) begin
        if (Halt) begin
          m_run = 1'b0; m_halted = 1'b1; m_count = m_count + 32'd1;
        end else begin
          pc4 = m_pc + 32'd4;
          if (JumpReg)             tgt = RegTarget;
          else if (Jump)           tgt = (pc4 & 32'hF000_0000) | ({6'd0, JumpIndex} * 32'd4);
          else if (Branch && Zero) tgt = pc4 + BranchOffset * 32'd4;
          else                     tgt = pc4;
          if ((tgt % 32'd4 == 32'd0) && (tgt / 32'd4 < 32'd100)) begin
            m_pc = tgt; m_count = m_count + 32'd1;
          end else begin
            m_run = 1'b0; m_fault = 1'b1; m_fault_addr = tgt;
          end
        end
      end
    end
  endtask

  task automatic clear_inputs();
    Stall = 1'b0; Halt = 1'b0; Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
    BranchOffset = 32'd0; RegTarget = 32'd0; JumpIndex = 26'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    clear_inputs();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 RST = 1'b0;
    model_reset();
    #1;
    checks += 7;
    if (PC !== 32'd0)         begin errors++; $display("FAIL reset_pc: got %h expected %h", PC, 32'd0); end
    if (PCPlus4 !== 32'd4)    begin errors++; $display("FAIL reset_pcplus4: got %h expected %h", PCPlus4, 32'd4); end
    if (Valid !== 1'b0)       begin errors++; $display("FAIL reset_valid: got %b expected 0", Valid); end
    if (Halted !== 1'b0)      begin errors++; $display("FAIL reset_halted: got %b expected 0", Halted); end
    if (Fault !== 1'b0)       begin errors++; $display("FAIL reset_fault: got %b expected 0", Fault); end
    if (FaultAddr !== 32'd0)  begin errors++; $display("FAIL reset_faultaddr: got %h expected 0", FaultAddr); end
    if (InstrCount !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", InstrCount); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_free_run();
    logic [31:0] want [4];
    want[0] = 32'd0; want[1] = 32'd4; want[2] = 32'd8; want[3] = 32'd12;
    checks++;
    if (Valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", Valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks += 3;
      if (PC !== want[i]) begin errors++; $display("FAIL free_run_pc[%0d]: got %h expected %h", i, PC, want[i]); end
      if (PC !== m_pc)    begin errors++; $display("FAIL free_run_model[%0d]: got %h expected %h", i, PC, m_pc); end
      if (Valid !== 1'b1) begin errors++; $display("FAIL free_run_valid[%0d]: got %b expected 1", i, Valid); end
    end
  endtask

  task automatic test_branch();
    tick();
    checks++;
    if (PC !== 32'h10) begin errors++; $display("FAIL branch_start: got %h expected %h", PC, 32'h10); end
    Branch = 1'b1; Zero = 1'b1; BranchOffset = 32'hFFFF_FFFE;
    tick();
    checks++;
    if (PC !== 32'h0C) begin errors++; $display("FAIL branch_taken: got %h expected %h", PC, 32'h0C); end
    clear_inputs();
    tick();
    Branch = 1'b1; Zero = 1'b0; BranchOffset = 32'hFFFF_FFFE;
    tick();
    checks++;
    if (PC !== 32'h14) begin errors++; $display("FAIL branch_not_taken: got %h expected %h", PC, 32'h14); end
    clear_inputs();
  endtask

  task automatic test_priority();
    JumpReg = 1'b1; RegTarget = 32'h40; Jump = 1'b1; JumpIndex = 26'd7;
    Branch = 1'b1; Zero = 1'b1; BranchOffset = 32'd3;
    tick();
    checks += 2;
    if (PC !== 32'h40)      begin errors++; $display("FAIL priority_pc: got %h expected %h", PC, 32'h40); end
    if (PCPlus4 !== 32'h44) begin errors++; $display("FAIL priority_pcplus4: got %h expected %h", PCPlus4, 32'h44); end
    clear_inputs();
  endtask

  task automatic test_misaligned_jr();
    do_reset();
    tick();
    tick();
    JumpReg = 1'b1; RegTarget = 32'h42;
    tick();
    checks += 4;
    if (Fault !== 1'b1)        begin errors++; $display("FAIL jr_fault: got %b expected 1", Fault); end
    if (PC !== 32'h4)          begin errors++; $display("FAIL jr_pc_hold: got %h expected %h", PC, 32'h4); end
    if (FaultAddr !== 32'h42)  begin errors++; $display("FAIL jr_faultaddr: got %h expected %h", FaultAddr, 32'h42); end
    if (Valid !== 1'b0)        begin errors++; $display("FAIL jr_valid: got %b expected 0", Valid); end
    for (int i = 0; i < 5; i++) begin
      Jump = 1'($urandom); JumpIndex = 26'($urandom_range(0, 50)); RegTarget = 32'h20;
      tick();
      checks += 2;
      if (PC !== 32'h4)   begin errors++; $display("FAIL jr_frozen[%0d]: got %h expected %h", i, PC, 32'h4); end
      if (Fault !== 1'b1) begin errors++; $display("FAIL jr_fault_sticky[%0d]: got %b expected 1", i, Fault); end
    end
    clear_inputs();
  endtask

  task automatic test_out_of_range();
    do_reset();
    tick();
    tick();
    tick();
    Jump = 1'b1; JumpIndex = 26'd100;
    tick();
    checks += 3;
    if (Fault !== 1'b1)        begin errors++; $display("FAIL oor_fault: got %b expected 1", Fault); end
    if (FaultAddr !== 32'h190) begin errors++; $display("FAIL oor_faultaddr: got %h expected %h", FaultAddr, 32'h190); end
    if (PC !== 32'h8)          begin errors++; $display("FAIL oor_pc_hold: got %h expected %h", PC, 32'h8); end
    clear_inputs();
    #2 RST = 1'b0;
    model_reset();
    #1;
    checks += 3;
    if (PC !== 32'd0)        begin errors++; $display("FAIL oor_async_pc: got %h expected 0", PC); end
    if (Fault !== 1'b0)      begin errors++; $display("FAIL oor_async_fault: got %b expected 0", Fault); end
    if (FaultAddr !== 32'd0) begin errors++; $display("FAIL oor_async_faultaddr: got %h expected 0", FaultAddr); end
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_stall_halt();
    logic [31:0] seven;
`ifdef PC_PERF_CNT_EN
    seven = 32'd7;
`else
    seven = 32'd0;
`endif
    do_reset();
    tick();
    for (int i = 0; i < 7; i++) begin
      Stall = 1'b1;
      tick();
      checks++;
      if (PC !== m_pc) begin errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, PC, m_pc); end
      Stall = 1'b0;
      tick();
    end
    checks += 2;
    if (PC !== 32'd28)      begin errors++; $display("FAIL stall_steps_pc: got %h expected %h", PC, 32'd28); end
    if (InstrCount !== seven) begin errors++; $display("FAIL stall_count: got %0d expected %0d", InstrCount, seven); end
    Stall = 1'b1; Halt = 1'b1;
    tick();
    checks += 3;
    if (PC !== 32'd28)   begin errors++; $display("FAIL stallhalt_pc: got %h expected %h", PC, 32'd28); end
    if (Halted !== 1'b0) begin errors++; $display("FAIL stallhalt_halted: got %b expected 0", Halted); end
    if (Valid !== 1'b1)  begin errors++; $display("FAIL stallhalt_valid: got %b expected 1", Valid); end
    Stall = 1'b0;
    tick();
    checks += 4;
    if (Halted !== 1'b1)          begin errors++; $display("FAIL halt_halted: got %b expected 1", Halted); end
    if (Valid !== 1'b0)           begin errors++; $display("FAIL halt_valid: got %b expected 0", Valid); end
    if (PC !== 32'd28)            begin errors++; $display("FAIL halt_pc: got %h expected %h", PC, 32'd28); end
    if (InstrCount !== exp_count()) begin errors++; $display("FAIL halt_count: got %0d expected %0d", InstrCount, exp_count()); end
    Halt = 1'b0; JumpReg = 1'b1; RegTarget = 32'h40;
    tick();
    tick();
    checks += 2;
    if (PC !== 32'd28)   begin errors++; $display("FAIL halt_sticky_pc: got %h expected %h", PC, 32'd28); end
    if (Halted !== 1'b1) begin errors++; $display("FAIL halt_sticky: got %b expected 1", Halted); end
    clear_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ((m_halted || m_fault) && ($urandom % 4 == 0)) begin
        do_reset();
      end
      Stall        = ($urandom % 8 == 0);
      Halt         = ($urandom % 64 == 0);
      Branch       = 1'($urandom);
      Zero         = 1'($urandom);
      BranchOffset = 32'($urandom_range(0, 40)) - 32'd20;
      Jump         = ($urandom % 6 == 0);
      JumpIndex    = 26'($urandom_range(0, 110));
      JumpReg      = ($urandom % 8 == 0);
      RegTarget    = 32'($urandom_range(0, 110)) * 32'd4 + (($urandom % 4 == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      tick();
      checks += 7;
      if (PC !== m_pc)                begin errors++; $display("FAIL rand_pc[%0d]: got %h expected %h", i, PC, m_pc); end
      if (PCPlus4 !== m_pc + 32'd4)   begin errors++; $display("FAIL rand_pcplus4[%0d]: got %h expected %h", i, PCPlus4, m_pc + 32'd4); end
      if (Valid !== m_run)            begin errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, Valid, m_run); end
      if (Halted !== m_halted)        begin errors++; $display("FAIL rand_halted[%0d]: got %b expected %b", i, Halted, m_halted); end
      if (Fault !== m_fault)          begin errors++; $display("FAIL rand_fault[%0d]: got %b expected %b", i, Fault, m_fault); end
      if (FaultAddr !== m_fault_addr) begin errors++; $display("FAIL rand_faultaddr[%0d]: got %h expected %h", i, FaultAddr, m_fault_addr); end
      if (InstrCount !== exp_count()) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, InstrCount, exp_count()); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_priority();
    test_misaligned_jr();
    test_out_of_range();
    test_stall_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
